core_sequencer: RTL and testbench

Multi-cycle phase controller for the sequential core. It replaces hard-wired single-cycle enables with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It supports variable-latency fetch/LSU handshakes, bus timeouts, trap redirection, halt requests and a retired-instruction counter. It sits beside the control unit and gates the fetch unit, load/store unit and register-file write port.

---
 rtl/core_sequencer_pkg.sv | 25 ++
 rtl/core_sequencer_if.sv | 42 ++++
 rtl/core_sequencer_bus_timeout_counter.sv | 36 +++
 rtl/core_sequencer.sv | 141 ++++++++++++++
 tb/tb_core_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared constants for the core phase sequencer: state encoding, trap causes
// and the instruction size used for sequential PC advance.
package core_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  localparam logic [2:0] CAUSE_NONE          = 3'd0;
  localparam logic [2:0] CAUSE_FETCH_TIMEOUT = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL       = 3'd2;
  localparam logic [2:0] CAUSE_LSU_TIMEOUT   = 3'd3;
  localparam logic [2:0] CAUSE_MISALIGNED    = 3'd4;

  localparam int unsigned INSN_BYTES = 4;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Signal bundle between the phase sequencer and the fetch unit, LSU,
// control unit and register file.
interface core_sequencer_if #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned COUNTER_WIDTH = 64
);
  logic                     halt_request;
  logic                     fetch_done;
  logic                     illegal_instruction;
  logic                     memory_access;
  logic                     lsu_done;
  logic                     write_required;
  logic                     jump_branch_enable;
  logic [XLEN-1:0]          jump_target;
  logic                     fetch_enable;
  logic                     lsu_enable;
  logic                     register_write_enable;
  logic [XLEN-1:0]          PC;
  logic                     halted;
  logic                     trap_valid;
  logic [2:0]               trap_cause;
  logic [XLEN-1:0]          trap_PC;
  logic [COUNTER_WIDTH-1:0] retired_count;
  logic [2:0]               dbg_state;

  // Handshakes: fetch_enable / lsu_enable act as a request held high until the
  // matching fetch_done / lsu_done is seen on a clock edge; a done is a
  // one-edge acknowledge and is ignored whenever its request is low.
  modport master (
    input  halt_request, fetch_done, illegal_instruction, memory_access,
           lsu_done, write_required, jump_branch_enable, jump_target,
    output fetch_enable, lsu_enable, register_write_enable, PC, halted,
           trap_valid, trap_cause, trap_PC, retired_count, dbg_state
  );

  modport slave (
    output halt_request, fetch_done, illegal_instruction, memory_access,
           lsu_done, write_required, jump_branch_enable, jump_target,
    input  fetch_enable, lsu_enable, register_write_enable, PC, halted,
           trap_valid, trap_cause, trap_PC, retired_count, dbg_state
  );
endinterface

// File: rtl/core_sequencer_bus_timeout_counter.sv
// Counts consecutive wait cycles of a bus handshake and flags the cycle on
// which the wait limit is reached; a limit of 0 disables the timeout.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires on the wait cycle that brings the count up to the limit.
  assign expired = (TIMEOUT_CYCLES != 0) && count && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle phase controller: steps each instruction through fetch, decode,
// execute, memory and writeback, with bus timeouts, traps and halt support.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  RESET_PC       = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR    = XLEN'(32'h0000_0100),
  parameter int unsigned      TIMEOUT_CYCLES = 16,
  parameter int unsigned      COUNTER_WIDTH  = 64
) (
  input logic              CLK,
  input logic              reset,
  core_sequencer_if.master bus
);
  logic [2:0]               state_q, state_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [COUNTER_WIDTH-1:0] retired_q, retired_d;
  logic [2:0]               cause_q, cause_d;
  logic [XLEN-1:0]          trap_pc_q, trap_pc_d;
  logic                     rwe_q, rwe_d;

  logic       enter_trap;
  logic [2:0] new_cause;
  logic       wb_misaligned;
  logic       tmo_count;
  logic       tmo_expired;

  assign wb_misaligned = bus.jump_branch_enable && is_misaligned(bus.jump_target[1:0]);
  assign tmo_count = ((state_q == ST_FETCH)  && !bus.fetch_done) ||
                     ((state_q == ST_MEMORY) && !bus.lsu_done);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst     (reset),
    .clear   (state_d != state_q),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    cause_d    = cause_q;
    trap_pc_d  = trap_pc_q;
    rwe_d      = 1'b0;
    enter_trap = 1'b0;
    new_cause  = CAUSE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (!bus.halt_request) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.fetch_done) begin
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          enter_trap = 1'b1;
          new_cause  = CAUSE_FETCH_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (bus.illegal_instruction) begin
          enter_trap = 1'b1;
          new_cause  = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (bus.memory_access) begin
          state_d = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
          rwe_d   = bus.write_required && !wb_misaligned;
        end
      end
      ST_MEMORY: begin
        if (bus.lsu_done) begin
          state_d = ST_WRITEBACK;
          rwe_d   = bus.write_required && !wb_misaligned;
        end else if (tmo_expired) begin
          enter_trap = 1'b1;
          new_cause  = CAUSE_LSU_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        if (wb_misaligned) begin
          enter_trap = 1'b1;
          new_cause  = CAUSE_MISALIGNED;
        end else begin
          pc_d      = bus.jump_branch_enable ? bus.jump_target : pc_q + XLEN'(INSN_BYTES);
          retired_d = retired_q + COUNTER_WIDTH'(1);
          state_d   = bus.halt_request ? ST_IDLE : ST_FETCH;
        end
      end
      ST_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = bus.halt_request ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    // Cause and faulting PC are latched on entry so they are valid during the pulse.
    if (enter_trap) begin
      state_d   = ST_TRAP;
      cause_d   = new_cause;
      trap_pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
      trap_pc_q <= '0;
      rwe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      trap_pc_q <= trap_pc_d;
      rwe_q     <= rwe_d;
    end
  end

  assign bus.fetch_enable          = (state_q == ST_FETCH);
  assign bus.lsu_enable            = (state_q == ST_MEMORY);
  assign bus.register_write_enable = rwe_q;
  assign bus.PC                    = pc_q;
  assign bus.halted                = (state_q == ST_IDLE);
  assign bus.trap_valid            = (state_q == ST_TRAP);
  assign bus.trap_cause            = cause_q;
  assign bus.trap_PC               = trap_pc_q;
  assign bus.retired_count         = retired_q;
  assign bus.dbg_state             = state_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-instruction phase/latency checks plus
// a scoreboard of expected writeback PCs and trap records.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic CLK;
  logic reset;

  int vectors;
  int miscompares;

  logic [31:0] we_q[$];
  logic [34:0] trap_q[$];

  core_sequencer_if #(.XLEN(32), .COUNTER_WIDTH(64)) sif ();

  core_sequencer #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .TRAP_VECTOR    (32'h0000_0100),
    .TIMEOUT_CYCLES (16),
    .COUNTER_WIDTH  (64)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (sif)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: writeback strobes and trap pulses pop their expected records.
  always @(negedge CLK) begin
    if (!reset) begin
      if (sif.register_write_enable) begin
        check("wb_expected", we_q.size() != 0, 1);
        if (we_q.size() != 0) check("wb_pc", sif.PC, we_q.pop_front());
      end
      if (sif.trap_valid) begin
        check("trap_expected", trap_q.size() != 0, 1);
        if (trap_q.size() != 0) check("trap_rec", {sif.trap_cause, sif.trap_PC}, trap_q.pop_front());
      end
    end
  end

  // Driver: launches one instruction from IDLE and runs it back to IDLE.
  task automatic run_insn(input int fetch_delay, input int lsu_delay, input bit halt_in_mem,
                          output int lat, output int fe_cyc, output int lsu_cyc,
                          output int rwe_cnt, output int rwe_at, output int trap_cnt,
                          output logic fe1, output logic [31:0] first_pc);
    bit done;
    done = 0; lat = 0; fe_cyc = 0; lsu_cyc = 0; rwe_cnt = 0; rwe_at = 0; trap_cnt = 0;
    fe1 = 1'b0; first_pc = '0;
    if (fetch_delay > 0) sif.fetch_done = 1'b0;
    if (lsu_delay > 0) sif.lsu_done = 1'b0;
    sif.halt_request = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (!halt_in_mem) sif.halt_request = 1'b1;
      if (sif.halted) begin
        done = 1;
      end else begin
        lat++;
        if (lat == 1) begin
          fe1 = sif.fetch_enable;
          first_pc = sif.PC;
        end
        if (sif.fetch_enable) begin
          fe_cyc++;
          if (fe_cyc == fetch_delay) sif.fetch_done = 1'b1;
        end
        if (sif.lsu_enable) begin
          lsu_cyc++;
          if (halt_in_mem) sif.halt_request = 1'b1;
          if (lsu_cyc == lsu_delay) sif.lsu_done = 1'b1;
        end
        if (sif.register_write_enable) begin
          rwe_cnt++;
          rwe_at = lat;
        end
        if (sif.trap_valid) trap_cnt++;
      end
    end
    check("run_bounded", done, 1);
    sif.fetch_done   = 1'b1;
    sif.lsu_done     = 1'b1;
    sif.halt_request = 1'b1;
  endtask

  initial begin
    int lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt;
    logic fe1;
    logic [31:0] first_pc;

    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    sif.halt_request        = 1'b0;
    sif.fetch_done          = 1'b1;
    sif.illegal_instruction = 1'b0;
    sif.memory_access       = 1'b0;
    sif.lsu_done            = 1'b1;
    sif.write_required      = 1'b1;
    sif.jump_branch_enable  = 1'b0;
    sif.jump_target         = '0;
    repeat (3) @(negedge CLK);

    check("rst_halted", sif.halted, 1);
    check("rst_fetch_en", sif.fetch_enable, 0);
    check("rst_lsu_en", sif.lsu_enable, 0);
    check("rst_rwe", sif.register_write_enable, 0);
    check("rst_trap_valid", sif.trap_valid, 0);
    check("rst_pc", sif.PC, 32'h0);
    check("rst_retired", sif.retired_count, 0);
    check("rst_cause", sif.trap_cause, 0);
    check("rst_trap_pc", sif.trap_PC, 0);
    check("rst_state", sif.dbg_state, ST_IDLE);
    reset = 1'b0;

    // 1: plain ALU instruction, fetch and LSU acks tied high
    we_q.push_back(32'h0);
    run_insn(0, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t1_fe_cycle1", fe1, 1);
    check("t1_first_pc", first_pc, 32'h0);
    check("t1_latency", lat, 4);
    check("t1_fe_cycles", fe_cyc, 1);
    check("t1_lsu_cycles", lsu_cyc, 0);
    check("t1_rwe_at", rwe_at, 4);
    check("t1_rwe_cnt", rwe_cnt, 1);
    check("t1_pc", sif.PC, 32'h4);
    check("t1_retired", sif.retired_count, 1);

    // 2: load/store with a 3-cycle LSU
    sif.memory_access = 1'b1;
    we_q.push_back(32'h4);
    run_insn(0, 3, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    sif.memory_access = 1'b0;
    check("t2_lsu_cycles", lsu_cyc, 3);
    check("t2_latency", lat, 7);
    check("t2_rwe_at", rwe_at, 7);
    check("t2_pc", sif.PC, 32'h8);
    check("t2_retired", sif.retired_count, 2);

    // 3a: aligned taken jump
    sif.jump_branch_enable = 1'b1;
    sif.jump_target = 32'h40;
    we_q.push_back(32'h8);
    run_insn(0, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t3a_latency", lat, 4);
    check("t3a_pc", sif.PC, 32'h40);
    check("t3a_retired", sif.retired_count, 3);

    // 3b: misaligned jump target traps in writeback
    sif.jump_target = 32'h42;
    trap_q.push_back({CAUSE_MISALIGNED, 32'h40});
    run_insn(0, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    sif.jump_branch_enable = 1'b0;
    sif.jump_target = '0;
    check("t3b_latency", lat, 5);
    check("t3b_trap_cnt", trap_cnt, 1);
    check("t3b_rwe_cnt", rwe_cnt, 0);
    check("t3b_pc", sif.PC, 32'h100);
    check("t3b_retired", sif.retired_count, 3);
    check("t3b_cause_held", sif.trap_cause, 4);
    check("t3b_trap_pc_held", sif.trap_PC, 32'h40);

    // 4a: fetch never acknowledged
    trap_q.push_back({CAUSE_FETCH_TIMEOUT, 32'h100});
    run_insn(99, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t4a_fe_cycles", fe_cyc, 16);
    check("t4a_latency", lat, 17);
    check("t4a_trap_cnt", trap_cnt, 1);
    check("t4a_pc", sif.PC, 32'h100);
    check("t4a_cause", sif.trap_cause, 1);

    // 4b: fetch ack on the last allowed cycle
    we_q.push_back(32'h100);
    run_insn(16, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t4b_first_pc", first_pc, 32'h100);
    check("t4b_fe_cycles", fe_cyc, 16);
    check("t4b_latency", lat, 19);
    check("t4b_trap_cnt", trap_cnt, 0);
    check("t4b_pc", sif.PC, 32'h104);
    check("t4b_retired", sif.retired_count, 4);

    // 5: illegal instruction
    sif.illegal_instruction = 1'b1;
    trap_q.push_back({CAUSE_ILLEGAL, 32'h104});
    run_insn(0, 0, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    sif.illegal_instruction = 1'b0;
    check("t5_latency", lat, 3);
    check("t5_rwe_cnt", rwe_cnt, 0);
    check("t5_pc", sif.PC, 32'h100);
    check("t5_retired", sif.retired_count, 4);
    check("t5_cause", sif.trap_cause, 2);

    // 5b: LSU never acknowledged
    sif.memory_access = 1'b1;
    trap_q.push_back({CAUSE_LSU_TIMEOUT, 32'h100});
    run_insn(0, 99, 0, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t5b_lsu_cycles", lsu_cyc, 16);
    check("t5b_latency", lat, 20);
    check("t5b_rwe_cnt", rwe_cnt, 0);
    check("t5b_cause", sif.trap_cause, 3);

    // 6: halt raised in MEMORY lets the instruction finish and retire
    we_q.push_back(32'h100);
    run_insn(0, 2, 1, lat, fe_cyc, lsu_cyc, rwe_cnt, rwe_at, trap_cnt, fe1, first_pc);
    check("t6_latency", lat, 6);
    check("t6_rwe_cnt", rwe_cnt, 1);
    check("t6_pc", sif.PC, 32'h104);
    check("t6_retired", sif.retired_count, 5);
    repeat (2) @(negedge CLK);
    check("t6_idle_halted", sif.halted, 1);
    check("t6_idle_no_fetch", sif.fetch_enable, 0);

    // 6b: asynchronous reset in the middle of a memory access
    sif.lsu_done = 1'b0;
    sif.halt_request = 1'b0;
    @(negedge CLK);
    sif.halt_request = 1'b1;
    repeat (3) @(negedge CLK);
    check("t6b_in_memory", sif.lsu_enable, 1);
    #2 reset = 1'b1;
    #1;
    check("t6b_halted", sif.halted, 1);
    check("t6b_lsu_en", sif.lsu_enable, 0);
    check("t6b_fetch_en", sif.fetch_enable, 0);
    check("t6b_rwe", sif.register_write_enable, 0);
    check("t6b_trap_valid", sif.trap_valid, 0);
    check("t6b_pc", sif.PC, 32'h0);
    check("t6b_retired", sif.retired_count, 0);
    check("t6b_cause", sif.trap_cause, 0);
    check("t6b_trap_pc", sif.trap_PC, 0);
    @(negedge CLK);
    reset = 1'b0;
    sif.memory_access = 1'b0;
    sif.lsu_done = 1'b1;
    repeat (2) @(negedge CLK);

    // Final report
    check("sb_wb_drained", we_q.size(), 0);
    check("sb_trap_drained", trap_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
